// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
//   Round-robin scheduler sharing one 8:1 single-bit mux among eight requesters.
//   A requester holds the grant for at most MAX_BURST accepted transfers, then the
//   grant rotates. One IDLE cycle always separates two grants.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   req[7:0]   : per-requester request
//   din[7:0]   : per-requester data bit (mux inputs)
//   out_ready  : downstream accepts out_data this cycle
//   sel[2:0]   : registered mux select (index of granted requester)
//   gnt[7:0]   : registered one-hot grant, zero when idle
//   out_valid  : selected bit is valid
//   out_data   : din[sel], the mux output
//   active     : high while a grant is held
module mux8_rr_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic [7:0] din,
   input  logic       out_ready,
   output logic [2:0] sel,
   output logic [7:0] gnt,
   output logic       out_valid,
   output logic       out_data,
   output logic       active
);

   localparam int unsigned    CntW    = $clog2(MAX_BURST + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StGrant = 1'b1;

   logic [0:0]      state_q, state_d;
   logic [2:0]      ptr_q, ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      sel_q, sel_d;
   logic [7:0]      gnt_q, gnt_d;

   logic [15:0] req_dbl;
   logic [7:0]  req_rot;
   logic [2:0]  pick_off;
   logic [2:0]  pick_idx;
   logic        xfer;
   logic        rel;

   // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
   assign req_dbl = {req, req};
   assign req_rot = req_dbl[ptr_q +: 8];

   always_comb begin
      pick_off = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (req_rot[i]) begin
            pick_off = 3'(i);
         end
      end
   end

   assign pick_idx = ptr_q + pick_off;

   // Outputs
   assign active    = (state_q == StGrant);
   assign out_valid = active & req[sel_q];
   assign out_data  = din[sel_q];
   assign sel       = sel_q;
   assign gnt       = gnt_q;

   assign xfer = out_valid & out_ready;
   // Release on request drop, or on the transfer that completes the burst.
   assign rel  = ~req[sel_q] | (xfer & (cnt_q == CntLast));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      case (state_q)
         StIdle: begin
            if (|req) begin
               state_d = StGrant;
               sel_d   = pick_idx;
               gnt_d   = 8'd1 << pick_idx;
               cnt_d   = '0;
            end else begin
               gnt_d = '0;
            end
         end
         StGrant: begin
            if (rel) begin
               state_d = StIdle;
               gnt_d   = '0;
               ptr_d   = sel_q + 3'd1;
               cnt_d   = '0;
            end else if (xfer) begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= 3'd0;
         cnt_q   <= '0;
         sel_q   <= 3'd0;
         gnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
      end
   end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter
//   Randomized bench for mux8_rr_arbiter, checked every cycle against a
//   behavioural model kept as plain integers (busy flag, granted index,
//   pointer, transfers-so-far).
module tb_mux8_rr_arbiter;

   localparam int unsigned MaxBurst = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] din;
   logic       out_ready;
   logic [2:0] sel;
   logic [7:0] gnt;
   logic       out_valid;
   logic       out_data;
   logic       active;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model state
   bit m_busy;
   int m_sel;
   int m_ptr;
   int m_xfers;

   logic [7:0] cur_req;

   mux8_rr_arbiter #(
      .MAX_BURST(MaxBurst)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .din      (din),
      .out_ready(out_ready),
      .sel      (sel),
      .gnt      (gnt),
      .out_valid(out_valid),
      .out_data (out_data),
      .active   (active)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%02h, expected 0x%02h", tag, $time, got, exp);
      end
   endtask

   // Apply one cycle of inputs, check outputs against the model, advance the model.
   task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] d,
                       input logic rdy);
      logic [7:0] e_gnt;
      logic       e_valid;
      logic       e_data;
      bit         found;
      int         idx;
      @(negedge clk);
      rst       = r;
      req       = rq;
      din       = d;
      out_ready = rdy;
      #1;
      e_valid = m_busy && rq[m_sel];
      e_data  = d[m_sel];
      e_gnt   = m_busy ? (8'd1 << m_sel) : 8'd0;
      check_eq("sel", {5'd0, sel}, 8'(m_sel));
      check_eq("gnt", gnt, e_gnt);
      check_eq("out_valid", {7'd0, out_valid}, {7'd0, e_valid});
      check_eq("out_data", {7'd0, out_data}, {7'd0, e_data});
      check_eq("active", {7'd0, active}, {7'd0, m_busy});
      if (r) begin
         m_busy  = 0;
         m_sel   = 0;
         m_ptr   = 0;
         m_xfers = 0;
      end else if (!m_busy) begin
         found = 0;
         for (int k = 0; k < 8; k++) begin
            idx = (m_ptr + k) % 8;
            if (!found && rq[idx]) begin
               found   = 1;
               m_sel   = idx;
               m_busy  = 1;
               m_xfers = 0;
            end
         end
      end else begin
         if (e_valid && rdy) m_xfers++;
         if (!rq[m_sel] || m_xfers == int'(MaxBurst)) begin
            m_busy  = 0;
            m_ptr   = (m_sel + 1) % 8;
            m_xfers = 0;
         end
      end
   endtask

   function automatic logic [7:0] flip_mask(input int unsigned odds);
      logic [7:0] m;
      m = 8'd0;
      for (int b = 0; b < 8; b++) begin
         if ($urandom_range(odds - 1) == 0) m[b] = 1'b1;
      end
      return m;
   endfunction

   initial begin
      rst       = 1'b1;
      req       = 8'hFF;
      din       = 8'h00;
      out_ready = 1'b0;
      m_busy    = 0;
      m_sel     = 0;
      m_ptr     = 0;
      m_xfers   = 0;
      repeat (2) @(posedge clk);

      // Reset held with all requests high, then release: first grant goes to 0.
      repeat (2) step(1'b1, 8'hFF, 8'($urandom), 1'b1);

      // Fairness: everyone requesting, downstream always ready.
      repeat (90) step(1'b0, 8'hFF, 8'($urandom), 1'b1);

      // Single requester 5 with toggling data.
      repeat (30) step(1'b0, 8'h20, 8'($urandom), 1'b1);

      // Single requester 3 under random backpressure.
      repeat (60) step(1'b0, 8'h08, 8'($urandom), ($urandom_range(2) != 0));

      // Held requests that occasionally drop or rise, random backpressure.
      cur_req = 8'h44;
      repeat (1200) begin
         cur_req = cur_req ^ flip_mask(12);
         step(1'b0, cur_req, 8'($urandom), ($urandom_range(3) != 0));
      end

      // Same with occasional resets landing mid-burst.
      repeat (1200) begin
         cur_req = cur_req ^ flip_mask(8);
         step(($urandom_range(29) == 0), cur_req, 8'($urandom), ($urandom_range(3) != 0));
      end

      // Sparse requests: mostly idle with the odd short request.
      repeat (400) begin
         step(1'b0, 8'($urandom) & 8'($urandom) & 8'($urandom), 8'($urandom),
              ($urandom_range(1) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin scheduler that shares one 8:1 single-bit mux channel among eight requesters. It picks one requester at a time, drives the mux select lines (`sel[2]`/`sel[1]`/`sel[0]` map to `s2`/`s1`/`s0`), and holds the grant for a bounded burst of transferred bits. It forwards the selected bit downstream under a valid/ready handshake. It sits between the requester front-ends and the 8:1 mux datapath. Its `sel` output wires directly to the mux select inputs.

## Interface

Parameters:
- `MAX_BURST`, default 4: maximum number of accepted transfers per grant before forced rotation. Legal range 1..255.

Ports (name, direction, width, meaning):
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, 8: per-requester request; bit i = requester i wants the channel.
- `din`, input, 8: per-requester data bit; bit i is mux input `i<i>`.
- `out_ready`, input, 1: downstream accepts `out_data` this cycle.
- `sel`, output, 3: registered mux select; value = index of the granted requester.
- `gnt`, output, 8: registered one-hot grant, all-zero when idle.
- `out_valid`, output, 1: selected bit is valid.
- `out_data`, output, 1: equals `din[sel]`, i.e. the mux output.
- `active`, output, 1: high while in GRANT.

## Operation

- **State machine:** two states, IDLE and GRANT.
- **Internal state:**
  - `ptr[2:0]`: priority pointer, the first index examined.
  - `cnt`: transfer counter, width `$clog2(MAX_BURST+1)`.
- **IDLE:**
  - If `req != 0`, choose the first asserted index scanning `ptr`, `ptr+1`, …, `ptr+7` (mod 8).
  - On the next edge: load `sel` with that index, set `gnt = 1<<index`, clear `cnt`, go to GRANT.
  - If `req == 0`, stay in IDLE with `gnt = 0`. `sel` holds its last value.
- **GRANT:**
  - `out_valid = req[sel]`.
  - A transfer occurs when `out_valid && out_ready`; `cnt` increments on each transfer.
  - **Release condition:** `req[sel] == 0`, OR (transfer this cycle AND `cnt == MAX_BURST-1`).
  - **On release, at the next edge:**
    - Go to IDLE.
    - Clear `gnt`.
    - Set `ptr = sel + 1` (mod 8; 7 wraps to 0).
    - Clear `cnt`.
  - **Otherwise:** hold `sel`, `gnt`, `ptr`.
- Requests from non-granted requesters are ignored until the next IDLE cycle. They are never lost while held high.
- **Simultaneous events:**
  - Final burst transfer and `req[sel]` dropping in the same cycle: one release, `ptr = sel+1`.
  - `req[sel]` drops while `out_ready = 0`: release with no transfer.
- **Backpressure:** while `out_ready = 0`, `cnt`, `sel` and `gnt` are frozen; there is no timeout.
- **Single requester:** it is re-granted after the IDLE bubble, since the pointer scan wraps back to it.
- **Reset:** `rst` high at any edge, including mid-burst, forces:
  - state = IDLE;
  - `ptr = 0`, `cnt = 0`, `sel = 0`, `gnt = 0`.
  - `out_valid = 0` and `active = 0` from that edge onward.

## Timing

- **Reset values:** `sel = 0`, `gnt = 0`, `out_valid = 0`, `active = 0`, `out_data = din[0]`.
- **Arbitration latency:** `req` sampled high in IDLE at edge N → `gnt`/`sel` valid after edge N. `out_valid` can rise in the same cycle.
- **Bubble between grants:** exactly 1 IDLE cycle (`gnt = 0`, `out_valid = 0`). Full-rate throughput is `MAX_BURST` transfers per `MAX_BURST+1` cycles.
- **Combinational paths:**
  - `out_valid` and `out_data` depend on registered `sel`/state plus the current `req`/`din`.
  - There is no combinational path from `out_ready` to `out_valid`.
  - `sel` and `gnt` are purely registered, so the select lines are glitch-free.

## Test plan

- **Reset:** `rst = 1` for 2 cycles with `req = 0xFF` → `gnt = 0`, `sel = 0`, `out_valid = 0`, `active = 0`. After release, first grant is index 0.
- **Single requester:** `req = 0x20` held, `din[5]` toggling, `out_ready = 1`, `MAX_BURST = 4` → `sel = 5`, `gnt = 0x20`; 4 transfers with `out_data = din[5]`; 1 IDLE cycle; then re-grant of 5.
- **Fairness:** `req = 0xFF` held, `out_ready = 1` → grant order 0,1,2,…,7,0. Each grant carries 4 transfers and is separated by 1 idle cycle.
- **Backpressure:** granted requester 3; `out_ready` low for 3 cycles after the 2nd transfer → `cnt`, `gnt = 0x08`, `sel = 3` held. Exactly 4 transfers total, then release.
- **Early drop and pointer wrap:**
  - Grant at 2; `req[2]` drops after 2 transfers; `req = 0x42` pending → release, `ptr = 3`, next grant 6.
  - Next case: grant at 7 releases → `ptr = 0`.
- **Reset mid-burst:** `rst` pulsed during the 2nd transfer of a grant at 4 → after the edge, `gnt = 0`, `out_valid = 0`, `sel = 0`. With `req = 0x11` held, the next grant is index 0.
